// File: rtl/bcd_sseg_pkg.sv
// Shared seven-segment types, glyph table and code-to-segment encoding.
package bcd_sseg_pkg;

  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active-high

  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_DASH  = 7'h40;

  localparam seg_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t enc_digit(input logic [3:0] code, input logic hex_mode);
    if ((code > 4'd9) && !hex_mode) begin
      return SEG_DASH;
    end
    return SEG_LUT[code];
  endfunction

endpackage

// File: rtl/bcd_sseg_scan_enc.sv
// Combinational encoder for one 4-bit digit code into active-high segments.
module sseg_digit_enc
  import bcd_sseg_pkg::*;
#(
  parameter int unsigned HEX_MODE = 0
) (
  input  logic [3:0] code,
  output seg_t       seg
);

  assign seg = enc_digit(code, HEX_MODE != 0);

endmodule

// File: rtl/bcd_sseg_scan.sv
// Time-multiplexed multi-digit seven-segment driver with leading-zero blanking,
// decimal points, invalid-code flagging and selectable pin polarity.
module bcd_sseg_scan
  import bcd_sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned HEX_MODE       = 0,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    err
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DivW = $clog2(REFRESH_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [NUM_DIGITS-1:0]   dp_sh_q;
  logic [DivW-1:0]         div_q, div_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    err_q, err_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;

  logic                    term;
  logic                    bad_code;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [3:0]              cur_code;
  seg_t                    cur_seg;

  assign term = (div_q == DivLast);

  // Divider and digit index; en low parks both at zero.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (!en) begin
      div_d = '0;
      idx_d = '0;
    end else if (term) begin
      div_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_comb begin
    bad_code = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_code = 1'b1;
    end
  end

  assign err_d = err_q | (load & bad_code & (HEX_MODE == 0));

  // A digit is blanked when it and every more-significant digit are zero.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      zero_run     = zero_run & (shadow_q[4*i +: 4] == 4'd0);
      blank_vec[i] = blank_lz & zero_run;
    end
  end

  assign cur_code = shadow_q[4*int'(idx_q) +: 4];

  sseg_digit_enc #(
    .HEX_MODE (HEX_MODE)
  ) u_enc (
    .code (cur_code),
    .seg  (cur_seg)
  );

  // Terminal count drives a one-cycle dark gap between slots to avoid ghosting.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    dig_d = '0;
    if (en) begin
      seg_d = blank_vec[idx_q] ? SEG_BLANK : cur_seg;
      dp_d  = dp_sh_q[idx_q];
      if (!term) dig_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      dp_sh_q  <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b0;
      dig_q    <= '0;
    end else begin
      if (load) begin
        shadow_q <= bcd_in;
        dp_sh_q  <= dp_in;
      end
      div_q <= div_d;
      idx_q <= idx_d;
      err_q <= err_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      dig_q <= dig_d;
    end
  end

  assign seg_out = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp_out  = (SEG_ACTIVE_LOW != 0) ? ~dp_q : dp_q;
  assign dig_sel = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_sseg_scan.sv
// Scoreboard bench: two DUT builds (decimal/active-high segs, hex/active-low segs)
// share stimulus; a monitor pops one expected record at the start of each slot.
module tb_bcd_sseg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, load, blank_lz;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, err_a, err_b;
  logic [3:0]  dig_a, dig_b;

  always #5 clk = ~clk;

  bcd_sseg_scan #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .blank_lz(blank_lz), .bcd_in(bcd_in),
    .dp_in(dp_in), .seg_out(seg_a), .dp_out(dp_a), .dig_sel(dig_a), .err(err_a)
  );

  bcd_sseg_scan #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .blank_lz(blank_lz), .bcd_in(bcd_in),
    .dp_in(dp_in), .seg_out(seg_b), .dp_out(dp_b), .dig_sel(dig_b), .err(err_b)
  );

  // seg_a: decimal-mode active-high pins; seg_b: hex-mode pins (already inverted).
  typedef struct {
    int         idx;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic       dp;
    int         gap;  // cycles since previous slot start, 0 = don't care
  } slot_t;

  slot_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic push_slot(input int idx, input logic [6:0] sa, input logic [6:0] sb_hi,
                           input logic dp, input int gap);
    logic [6:0] sb;
    sb = ~sb_hi;
    exp_q.push_back('{idx: idx, seg_a: sa, seg_b: sb, dp: dp, gap: gap});
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic scan(input int n);
    en = 1'b1;
    repeat (4 * n) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
  endtask

  // Monitor
  int    cyc = 0;
  int    last_start = 0;
  bit    prev_act = 1'b0;
  slot_t e;
  logic [3:0] oh, want_dig_a;
  logic       want_dp_b;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if ((dig_a != 4'hF) && !prev_act) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_slot: got dig_sel=%b required no slot", dig_a);
        end else begin
          e          = exp_q.pop_front();
          oh         = 4'b0001 << e.idx;
          want_dig_a = ~oh;
          want_dp_b  = !e.dp;
          chk("slot_dig_a", dig_a, want_dig_a);
          chk("slot_dig_b", dig_b, oh);
          chk("slot_seg_a", seg_a, e.seg_a);
          chk("slot_seg_b", seg_b, e.seg_b);
          chk("slot_dp_a", dp_a, e.dp);
          chk("slot_dp_b", dp_b, want_dp_b);
          if (e.gap != 0) chk("slot_gap", cyc - last_start, e.gap);
        end
        last_start = cyc;
      end
      prev_act = (dig_a != 4'hF);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; blank_lz = 1'b0; bcd_in = '0; dp_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_dig_a", dig_a, 4'hF);
    chk("rst_seg_a", seg_a, 7'h00);
    chk("rst_dp_a", dp_a, 1'b0);
    chk("rst_dig_b", dig_b, 4'h0);
    chk("rst_seg_b", seg_b, 7'h7F);
    chk("rst_dp_b", dp_b, 1'b1);
    chk("rst_err_a", err_a, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic scan with wrap
    do_load(16'h1234, 4'b0000);
    push_slot(0, 7'h66, 7'h66, 1'b0, 0);
    push_slot(1, 7'h4F, 7'h4F, 1'b0, 4);
    push_slot(2, 7'h5B, 7'h5B, 1'b0, 4);
    push_slot(3, 7'h06, 7'h06, 1'b0, 4);
    push_slot(0, 7'h66, 7'h66, 1'b0, 4);
    scan(5);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    push_slot(0, 7'h3F, 7'h3F, 1'b0, 0);
    push_slot(1, 7'h07, 7'h07, 1'b0, 4);
    push_slot(2, 7'h00, 7'h00, 1'b0, 4);
    push_slot(3, 7'h00, 7'h00, 1'b0, 4);
    scan(4);
    do_load(16'h0000, 4'b0000);
    push_slot(0, 7'h3F, 7'h3F, 1'b0, 0);
    push_slot(1, 7'h00, 7'h00, 1'b0, 4);
    push_slot(2, 7'h00, 7'h00, 1'b0, 4);
    push_slot(3, 7'h00, 7'h00, 1'b0, 4);
    scan(4);

    // Invalid code: dash + sticky err in decimal mode, 'A' in hex mode
    blank_lz = 1'b0;
    do_load(16'h00A5, 4'b0000);
    chk("err_a_set", err_a, 1'b1);
    chk("err_b_clear", err_b, 1'b0);
    push_slot(0, 7'h6D, 7'h6D, 1'b0, 0);
    push_slot(1, 7'h40, 7'h77, 1'b0, 4);
    push_slot(2, 7'h3F, 7'h3F, 1'b0, 4);
    push_slot(3, 7'h3F, 7'h3F, 1'b0, 4);
    scan(4);
    do_load(16'h0001, 4'b0000);
    chk("err_a_sticky", err_a, 1'b1);
    chk("err_b_still_clear", err_b, 1'b0);

    // Decimal points and segment polarity
    do_load(16'h8888, 4'b0100);
    push_slot(0, 7'h7F, 7'h7F, 1'b0, 0);
    push_slot(1, 7'h7F, 7'h7F, 1'b0, 4);
    push_slot(2, 7'h7F, 7'h7F, 1'b1, 4);
    push_slot(3, 7'h7F, 7'h7F, 1'b0, 4);
    scan(4);

    // Asynchronous reset mid-slot
    do_load(16'h1234, 4'b0000);
    push_slot(0, 7'h66, 7'h66, 1'b0, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dig_a", dig_a, 4'hF);
    chk("async_rst_seg_a", seg_a, 7'h00);
    chk("async_rst_dig_b", dig_b, 4'h0);
    chk("async_rst_seg_b", seg_b, 7'h7F);
    chk("async_rst_dp_b", dp_b, 1'b1);
    chk("async_rst_err_a", err_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push_slot(0, 7'h3F, 7'h3F, 1'b0, 0);
    push_slot(1, 7'h3F, 7'h3F, 1'b0, 4);
    @(posedge clk);
    #1 chk("first_after_reset", dig_a, 4'b1110);
    repeat (8) @(negedge clk);
    en = 1'b0;
    @(negedge clk);

    // en dropped mid-scan, then restarted
    do_load(16'h1234, 4'b0000);
    push_slot(0, 7'h66, 7'h66, 1'b0, 0);
    push_slot(1, 7'h4F, 7'h4F, 1'b0, 4);
    en = 1'b1;
    repeat (6) @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("en_off_dig_a", dig_a, 4'hF);
    chk("en_off_seg_a", seg_a, 7'h00);
    repeat (10) @(negedge clk);
    push_slot(0, 7'h66, 7'h66, 1'b0, 0);
    push_slot(1, 7'h4F, 7'h4F, 1'b0, 4);
    en = 1'b1;
    @(posedge clk);
    #1 chk("en_restart_dig_a", dig_a, 4'b1110);
    repeat (8) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_sseg_scan.md
Name: bcd_sseg_scan

Overview:
Parametrised multi-digit, time-multiplexed seven-segment display driver; successor to the single-digit combinational BCD decoder. Captures a packed multi-digit BCD word on a load strobe and scans one digit at a time at a programmable refresh rate. Adds leading-zero blanking, decimal points, hex/invalid-code handling and output polarity selection. Sits between the datapath (counters, ALU results) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>=2)
HEX_MODE, 0, 1: codes 10-15 show A,b,C,d,E,F; 0: they show dash (g only) and set err
SEG_ACTIVE_LOW, 0, 1: seg_out and dp_out inverted at the pins
DIG_ACTIVE_LOW, 1, 1: dig_sel active-low (common-anode)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable
load  in  1  capture strobe for bcd_in/dp_in
blank_lz  in  1  leading-zero blanking enable
bcd_in  in  4*NUM_DIGITS  packed digits, digit 0 = LSD in [3:0]
dp_in  in  NUM_DIGITS  decimal point per digit
seg_out  out  7  {g,f,e,d,c,b,a}
dp_out  out  1  decimal point of active digit
dig_sel  out  NUM_DIGITS  one-hot digit enable
err  out  1  sticky: an invalid code (>9, HEX_MODE=0) was loaded

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low, rst_n. All flops clear on rst_n low without waiting for a clock edge.
- Reset values: shadow digits 0, shadow dp 0, div counter 0, digit index 0, err 0. seg_out/dp_out are at the "off" level for their polarity, and dig_sel is all-inactive.
- Load: when load=1 at a rising edge, bcd_in/dp_in go into the shadow registers. The new value is visible on the next scanned slot output.
- err: sets on a load carrying any code >9 when HEX_MODE=0. It is cleared only by reset. It never sets when HEX_MODE=1.
- Divider: counts 0..REFRESH_DIV-1 while en=1. At terminal count it wraps to 0 and the digit index increments; index NUM_DIGITS-1 wraps to 0.
- Outputs are registered from the index: dig_sel and seg_out change 1 cycle after the index changes. Each slot lasts exactly REFRESH_DIV cycles.
- Ghost suppression: in the cycle where the divider is at terminal count, dig_sel is driven all-inactive for one cycle.
- en=0: divider and index synchronously clear to 0, dig_sel goes all-inactive and seg_out goes off on the next edge. Load still works.
- After en rises, digit 0 is driven on the following cycle.
- Encoding (active-high, hex):
  - 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F
  - A-F: 77,7C,39,5E,79,71
  - dash: 40
  - blank: 00
- Leading-zero blanking: with blank_lz=1, digit i>0 is blanked if digits NUM_DIGITS-1 down to i are all 0. Digit 0 is never blanked.
- A blanked digit still drives its dig_sel, with segments 00 and dp still shown.
- Polarity inversion is applied last, on the registered outputs.
- load and the terminal count in the same cycle: the index advances and the new digit uses the newly loaded shadow value one cycle later. No conflict.
- Reset mid-scan: outputs go off immediately. Scanning restarts at digit 0.

Decomposition:
- Package bcd_sseg_pkg holds:
  - seg_t (logic [6:0])
  - localparams SEG_BLANK, SEG_DASH and a 16-entry SEG_LUT array
  - function enc_digit(code, hex_mode) returning seg_t
- One sub-module is natural: sseg_digit_enc, a combinational code->segment encoder using the package function, instantiated once on the muxed digit.
- The top holds the divider, index, shadow registers, blanking logic and output registers.

Test Plan:
1. NUM_DIGITS=4, REFRESH_DIV=4. Reset, en=1, load bcd_in=16'h1234 -> slots cycle digit0..3 showing 66,4F,5B,06. dig_sel (active-low) goes 1110,1101,1011,0111, each 4 cycles including one all-1111 ghost cycle. The sequence wraps back to digit 0.
2. Load 16'h0070, blank_lz=1 -> digit3 and digit2 show 00, digit1 shows 07, digit0 shows 3F. Load 16'h0000 -> only digit0 shows 3F.
3. HEX_MODE=0, load 16'h00A5 -> digit1 shows 40 and err goes 1 and stays 1 after a later load of 16'h0001. With HEX_MODE=1 the same load makes digit1 show 77 and err stays 0.
4. dp_in=4'b0100, SEG_ACTIVE_LOW=1 -> dp_out=0 only during digit2 slots. seg_out for the '8' digit is 7'h00, and off is 7'h7F.
5. Drop rst_n mid-slot between edges -> outputs go off immediately without a clock. After release with en=1, digit 0 appears 1 cycle later.
6. Toggle en low for 10 cycles mid-scan -> dig_sel goes all-inactive next edge. After en returns high, scanning restarts at digit 0 with the divider at 0.
